ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register sitting directly upstream of the ALU; it feeds the ALU's A, B, ALUOp and ALUCruft inputs.
- Each cycle it captures one decoded instruction and resolves data hazards on the operands it presents to the ALU.
- Operand forwarding comes from the EX/MEM and MEM/WB stages; a load-use hazard produces a one-bubble stall.
- A flush input squashes the held instruction on a taken branch.

Parameters:
- XLEN, 32, datapath width; bit 0 is the MSB, matching the ALU.
- REGW, 5, register-number width.

Ports:
- clk  in  1  Rising-edge clock.
- reset_n  in  1  Asynchronous active-low reset.
- in_valid  in  1  Decode presents an instruction.
- in_ready  out  1  Stage accepts the instruction this cycle.
- in_fn  in  4  Abstract ALU function code (alu_fn_t).
- in_rs1, in_rs2  in  REGW each  Source register numbers.
- in_rs1_val, in_rs2_val  in  XLEN each  Register-file read data.
- in_imm  in  XLEN  Sign-extended immediate.
- in_use_imm  in  1  B operand is the immediate.
- in_rd  in  REGW  Destination register.
- in_wen  in  1  Instruction writes rd.
- in_is_load  in  1  Instruction is a load.
- exm_wen  in  1  EX/MEM holds a register write.
- exm_rd  in  REGW  EX/MEM destination.
- exm_val  in  XLEN  EX/MEM result.
- mwb_wen  in  1  MEM/WB holds a register write.
- mwb_rd  in  REGW  MEM/WB destination.
- mwb_val  in  XLEN  MEM/WB result.
- ex_hold  in  1  Downstream back-pressure.
- flush  in  1  Squash the held instruction.
- out_valid  out  1  ALU operands are valid.
- alu_a, alu_b  out  XLEN each  To ALU A and B.
- alu_op  out  3  To ALUOp.
- alu_cruft  out  2  To ALUCruft.
- out_rd  out  REGW  Destination register.
- out_wen  out  1  Write enable.
- out_is_load  out  1  Load flag.

Behaviour:
- Reset (async, reset_n=0): valid=0; all held fields=0; out_valid=0; alu_op=000; alu_cruft=00; outputs are zero-data.
- Register (rising edge): priority is flush > ex_hold > normal.
  - flush: valid<=0.
  - Else ex_hold: hold all fields.
  - Else valid<=in_valid&in_ready; fields load from the in_* ports when in_valid&in_ready.
- in_ready = ~ex_hold & ~load_use.
  - load_use = valid & is_load & wen & rd!=0 & (rd==in_rs1 | (rd==in_rs2 & ~in_use_imm)).
  - On load_use with no hold and no flush: a bubble is inserted (valid<=0) and decode holds; the next cycle accepts, and MEM/WB then forwards.
- Forwarding (combinational, after the register) applies per source:
  - If exm_wen & exm_rd==rs & rs!=0, use exm_val.
  - Else if mwb_wen & mwb_rd==rs & rs!=0, use mwb_val.
  - Else use the captured value.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- alu_b = held imm when use_imm, otherwise the forwarded rs2.
- Function mapping (package table, combinational from held fn):
  - ADD: 100/00.
  - SUB: 100/10.
  - AND: 001/00.
  - OR: 010/00.
  - XOR: 011/00.
  - SEQ: 101/10.
  - SNE: 101/00.
  - SLT: 110/10.
  - SGE: 110/00.
  - SGT: SLT with A and B swapped.
  - SLE: SGE with A and B swapped.
  - SLL/SRL/SRA: 000 with the package shift constants.
  - Swap is applied after forwarding and after immediate selection.
- When valid=0: out_valid=0, alu_op/alu_cruft=ADD, out_wen=0. Data outputs are don't-care but stable.
- flush and load_use in the same cycle: flush wins, valid<=0, in_ready still follows load_use.
- Latency: one cycle from acceptance to out_valid.

Decomposition:
- Package alu_pkg:
  - alu_fn_t enum.
  - ALUOP_* and CRUFT_* constants.
  - Shift cruft constants.
  - Function mapping table as a function.
- Sub-module fwd_mux: one instance per source operand (rs, held value, exm/mwb ports -> value).

Test Plan:
- Reset: hold reset_n=0 mid-stream -> out_valid=0 and alu_op=000 immediately (asynchronous), in_ready=1 after release.
- ADD r3,r1,r2 with r1=5, r2=7, no hazards -> next cycle alu_a=5, alu_b=7, alu_op=100, alu_cruft=00.
- Forward priority: rs1=4, exm_rd=4 val=0xAAAA0000, mwb_rd=4 val=0x11 -> alu_a=0xAAAA0000; set exm_wen=0 -> alu_a=0x11; rs1=0 -> alu_a=captured value.
- Load-use: LW r6 held, incoming ADD uses r6 -> in_ready=0 for one cycle, bubble (out_valid=0), then ADD accepted with mwb forwarding.
- SGT r1=3, r2=9 -> alu_a=9, alu_b=3, alu_op=110, alu_cruft=10.
- flush together with ex_hold -> out_valid=0 next cycle, then a new instruction is accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU encoding package for the ID/EX operand stage.
// Contents:
//   alu_fn_t   - abstract ALU function codes that decode produces
//   ALUOP_*    - 3-bit ALUOp encodings
//   CRUFT_*    - 2-bit ALUCruft encodings, including the shift variants
//   alu_ctl_t  - mapped control: ALUOp, ALUCruft and the A/B swap flag
//   alu_map()  - function code -> alu_ctl_t table
package alu_pkg;

    typedef enum logic [3:0] {
        FN_ADD = 4'd0,
        FN_SUB = 4'd1,
        FN_AND = 4'd2,
        FN_OR  = 4'd3,
        FN_XOR = 4'd4,
        FN_SEQ = 4'd5,
        FN_SNE = 4'd6,
        FN_SLT = 4'd7,
        FN_SGE = 4'd8,
        FN_SGT = 4'd9,
        FN_SLE = 4'd10,
        FN_SLL = 4'd11,
        FN_SRL = 4'd12,
        FN_SRA = 4'd13
    } alu_fn_t;

    localparam logic [2:0] ALUOP_SHIFT = 3'b000;
    localparam logic [2:0] ALUOP_AND   = 3'b001;
    localparam logic [2:0] ALUOP_OR    = 3'b010;
    localparam logic [2:0] ALUOP_XOR   = 3'b011;
    localparam logic [2:0] ALUOP_ADD   = 3'b100;
    localparam logic [2:0] ALUOP_EQ    = 3'b101;
    localparam logic [2:0] ALUOP_LT    = 3'b110;

    // Adder/comparator cruft: bit 1 selects subtract / "true" sense.
    localparam logic [1:0] CRUFT_NONE  = 2'b00;
    localparam logic [1:0] CRUFT_SUB   = 2'b10;

    // Shifter cruft: direction and arithmetic fill.
    localparam logic [1:0] CRUFT_SLL   = 2'b00;
    localparam logic [1:0] CRUFT_SRL   = 2'b10;
    localparam logic [1:0] CRUFT_SRA   = 2'b11;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] cruft;
        logic       swap;   // present B as A and A as B
    } alu_ctl_t;

    // SGT/SLE have no native encoding: they reuse SLT/SGE with swapped
    // operands. Unused codes fall back to ADD so the ALU never sees junk.
    function automatic alu_ctl_t alu_map(input logic [3:0] fn);
        alu_ctl_t c;
        c = '{op: ALUOP_ADD, cruft: CRUFT_NONE, swap: 1'b0};
        case (fn)
            FN_ADD: c = '{op: ALUOP_ADD,   cruft: CRUFT_NONE, swap: 1'b0};
            FN_SUB: c = '{op: ALUOP_ADD,   cruft: CRUFT_SUB,  swap: 1'b0};
            FN_AND: c = '{op: ALUOP_AND,   cruft: CRUFT_NONE, swap: 1'b0};
            FN_OR:  c = '{op: ALUOP_OR,    cruft: CRUFT_NONE, swap: 1'b0};
            FN_XOR: c = '{op: ALUOP_XOR,   cruft: CRUFT_NONE, swap: 1'b0};
            FN_SEQ: c = '{op: ALUOP_EQ,    cruft: CRUFT_SUB,  swap: 1'b0};
            FN_SNE: c = '{op: ALUOP_EQ,    cruft: CRUFT_NONE, swap: 1'b0};
            FN_SLT: c = '{op: ALUOP_LT,    cruft: CRUFT_SUB,  swap: 1'b0};
            FN_SGE: c = '{op: ALUOP_LT,    cruft: CRUFT_NONE, swap: 1'b0};
            FN_SGT: c = '{op: ALUOP_LT,    cruft: CRUFT_SUB,  swap: 1'b1};
            FN_SLE: c = '{op: ALUOP_LT,    cruft: CRUFT_NONE, swap: 1'b1};
            FN_SLL: c = '{op: ALUOP_SHIFT, cruft: CRUFT_SLL,  swap: 1'b0};
            FN_SRL: c = '{op: ALUOP_SHIFT, cruft: CRUFT_SRL,  swap: 1'b0};
            FN_SRA: c = '{op: ALUOP_SHIFT, cruft: CRUFT_SRA,  swap: 1'b0};
            default: c = '{op: ALUOP_ADD,  cruft: CRUFT_NONE, swap: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-operand forwarding mux.
// Ports:
//   rs                     - held source register number
//   held_val               - register-file value captured with the instruction
//   exm_wen/exm_rd/exm_val - EX/MEM write-back candidate (highest priority)
//   mwb_wen/mwb_rd/mwb_val - MEM/WB write-back candidate
//   val                    - resolved operand
// Register 0 is hard-wired zero, so it is never forwarded.
module fwd_mux #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] rs,
    input  logic [0:XLEN-1] held_val,
    input  logic            exm_wen,
    input  logic [REGW-1:0] exm_rd,
    input  logic [0:XLEN-1] exm_val,
    input  logic            mwb_wen,
    input  logic [REGW-1:0] mwb_rd,
    input  logic [0:XLEN-1] mwb_val,
    output logic [0:XLEN-1] val
);
    logic rs_nz;
    assign rs_nz = (rs != '0);

    always_comb begin
        val = held_val;
        if (exm_wen && exm_rd == rs && rs_nz)
            val = exm_val;
        else if (mwb_wen && mwb_rd == rs && rs_nz)
            val = mwb_val;
    end
endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register in front of the ALU.
// Captures one decoded instruction per cycle, forwards EX/MEM and MEM/WB
// results into the held operands, stalls one cycle on load-use, and maps
// the abstract function code onto ALUOp/ALUCruft (with A/B swap for
// SGT/SLE).
// Ports:
//   clk, reset_n                 - clock, async active-low reset
//   in_*                         - decoded instruction from decode; in_ready
//                                  is the accept handshake back to decode
//   exm_*, mwb_*                 - forwarding sources
//   ex_hold, flush               - downstream back-pressure, branch squash
//   out_valid, alu_a/b/op/cruft  - ALU inputs
//   out_rd, out_wen, out_is_load - side-band carried to later stages
module ex_operand_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_fn,
    input  logic [REGW-1:0] in_rs1,
    input  logic [REGW-1:0] in_rs2,
    input  logic [0:XLEN-1] in_rs1_val,
    input  logic [0:XLEN-1] in_rs2_val,
    input  logic [0:XLEN-1] in_imm,
    input  logic            in_use_imm,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_wen,
    input  logic            in_is_load,
    input  logic            exm_wen,
    input  logic [REGW-1:0] exm_rd,
    input  logic [0:XLEN-1] exm_val,
    input  logic            mwb_wen,
    input  logic [REGW-1:0] mwb_rd,
    input  logic [0:XLEN-1] mwb_val,
    input  logic            ex_hold,
    input  logic            flush,
    output logic            out_valid,
    output logic [0:XLEN-1] alu_a,
    output logic [0:XLEN-1] alu_b,
    output logic [2:0]      alu_op,
    output logic [1:0]      alu_cruft,
    output logic [REGW-1:0] out_rd,
    output logic            out_wen,
    output logic            out_is_load
);
    // Held instruction
    logic            valid;
    logic [3:0]      fn;
    logic [REGW-1:0] rs1, rs2, rd;
    logic [0:XLEN-1] rs1_val, rs2_val, imm;
    logic            use_imm, wen, is_load;

    logic            load_use, accept;
    logic [0:XLEN-1] fwd1, fwd2, b_sel;
    alu_ctl_t        ctl;

    // A load's data is not available until MEM/WB, so a consumer directly
    // behind it must wait one cycle. rs2 only counts when it is really read.
    assign load_use = valid & is_load & wen & (rd != '0) &
                      ((rd == in_rs1) | ((rd == in_rs2) & ~in_use_imm));
    assign in_ready = ~ex_hold & ~load_use;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid   <= 1'b0;
            fn      <= '0;
            rs1     <= '0;
            rs2     <= '0;
            rs1_val <= '0;
            rs2_val <= '0;
            imm     <= '0;
            use_imm <= 1'b0;
            rd      <= '0;
            wen     <= 1'b0;
            is_load <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!ex_hold) begin
            // A load-use stall lands here with accept=0: the bubble.
            valid <= accept;
            if (accept) begin
                fn      <= in_fn;
                rs1     <= in_rs1;
                rs2     <= in_rs2;
                rs1_val <= in_rs1_val;
                rs2_val <= in_rs2_val;
                imm     <= in_imm;
                use_imm <= in_use_imm;
                rd      <= in_rd;
                wen     <= in_wen;
                is_load <= in_is_load;
            end
        end
    end

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_a (
        .rs(rs1), .held_val(rs1_val),
        .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_val(exm_val),
        .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_val(mwb_val),
        .val(fwd1)
    );

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_b (
        .rs(rs2), .held_val(rs2_val),
        .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_val(exm_val),
        .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_val(mwb_val),
        .val(fwd2)
    );

    assign ctl   = alu_map(fn);
    assign b_sel = use_imm ? imm : fwd2;

    always_comb begin
        // Swap happens last so immediate forms of SGT/SLE work too.
        alu_a = ctl.swap ? b_sel : fwd1;
        alu_b = ctl.swap ? fwd1  : b_sel;

        // Idle slots present a harmless ADD; while reset is asserted the
        // control lines are driven all-zero.
        if (!reset_n) begin
            alu_op    = 3'b000;
            alu_cruft = 2'b00;
        end else if (valid) begin
            alu_op    = ctl.op;
            alu_cruft = ctl.cruft;
        end else begin
            alu_op    = ALUOP_ADD;
            alu_cruft = CRUFT_NONE;
        end
    end

    assign out_valid   = valid;
    assign out_rd      = rd;
    assign out_wen     = valid & wen;
    assign out_is_load = valid & is_load;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, plain ALU op, forwarding
// priority, load-use bubble, operand swap, hold, flush+hold, async reset.
module tb_ex_operand_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_fn;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [0:31] in_rs1_val, in_rs2_val, in_imm;
    logic        in_use_imm, in_wen, in_is_load;
    logic        exm_wen, mwb_wen;
    logic [4:0]  exm_rd, mwb_rd;
    logic [0:31] exm_val, mwb_val;
    logic        ex_hold, flush;
    logic        out_valid;
    logic [0:31] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [1:0]  alu_cruft;
    logic [4:0]  out_rd;
    logic        out_wen, out_is_load;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_fn(in_fn),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load),
        .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_val(exm_val),
        .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_val(mwb_val),
        .ex_hold(ex_hold), .flush(flush),
        .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_cruft(alu_cruft),
        .out_rd(out_rd), .out_wen(out_wen), .out_is_load(out_is_load)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] fn, input logic [4:0] rs1, input logic [31:0] v1,
                         input logic [4:0] rs2, input logic [31:0] v2,
                         input logic ui, input logic [31:0] imm,
                         input logic [4:0] rd, input logic ld);
        in_valid   = 1'b1;
        in_fn      = fn;
        in_rs1     = rs1;  in_rs1_val = v1;
        in_rs2     = rs2;  in_rs2_val = v2;
        in_use_imm = ui;   in_imm     = imm;
        in_rd      = rd;   in_wen     = 1'b1;
        in_is_load = ld;
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 0; in_fn = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rs1_val = 0; in_rs2_val = 0; in_imm = 0;
        in_use_imm = 0; in_wen = 0; in_is_load = 0;
        exm_wen = 0; exm_rd = 0; exm_val = 0;
        mwb_wen = 0; mwb_rd = 0; mwb_val = 0;
        ex_hold = 0; flush = 0;

        // Reset state
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_op",    32'(alu_op),    32'b000);
        chk("rst_cruft", 32'(alu_cruft), 32'b00);
        chk("rst_a",     alu_a,          32'd0);
        reset_n = 1'b1;
        #1;
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_op",    32'(alu_op),   32'b100);

        // ADD r3,r1,r2
        instr(FN_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'd0, 5'd3, 1'b0);
        step();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_a",     alu_a,          32'd5);
        chk("add_b",     alu_b,          32'd7);
        chk("add_op",    32'(alu_op),    32'b100);
        chk("add_cruft", 32'(alu_cruft), 32'b00);
        chk("add_rd",    32'(out_rd),    32'd3);
        chk("add_wen",   32'(out_wen),   32'd1);

        // Forward priority on rs1=4
        instr(FN_ADD, 5'd4, 32'h1234, 5'd0, 32'd0, 1'b1, 32'h10, 5'd8, 1'b0);
        exm_wen = 1; exm_rd = 5'd4; exm_val = 32'hAAAA0000;
        mwb_wen = 1; mwb_rd = 5'd4; mwb_val = 32'h11;
        step();
        chk("fwd_exm", alu_a, 32'hAAAA0000);
        chk("fwd_imm", alu_b, 32'h10);
        exm_wen = 0;
        #1;
        chk("fwd_mwb", alu_a, 32'h11);
        // rs1=0 with both sources claiming r0
        instr(FN_ADD, 5'd0, 32'h77, 5'd0, 32'd0, 1'b1, 32'h10, 5'd8, 1'b0);
        exm_wen = 1; exm_rd = 5'd0; mwb_rd = 5'd0;
        step();
        chk("fwd_r0", alu_a, 32'h77);
        exm_wen = 0; mwb_wen = 0;

        // Load-use: LW r6, then ADD r7,r6,r2
        instr(FN_ADD, 5'd1, 32'h100, 5'd0, 32'd0, 1'b1, 32'd4, 5'd6, 1'b1);
        step();
        chk("lw_valid", 32'(out_valid),   32'd1);
        chk("lw_load",  32'(out_is_load), 32'd1);
        instr(FN_ADD, 5'd6, 32'hDEAD, 5'd2, 32'd3, 1'b0, 32'd0, 5'd7, 1'b0);
        #1;
        chk("lu_ready", 32'(in_ready), 32'd0);
        step();
        chk("lu_bubble", 32'(out_valid), 32'd0);
        chk("lu_wen",    32'(out_wen),   32'd0);
        chk("lu_ready2", 32'(in_ready),  32'd1);
        step();
        mwb_wen = 1; mwb_rd = 5'd6; mwb_val = 32'h55;
        #1;
        chk("lu_valid", 32'(out_valid), 32'd1);
        chk("lu_a",     alu_a,          32'h55);
        chk("lu_b",     alu_b,          32'd3);
        mwb_wen = 0;

        // SGT swaps operands
        instr(FN_SGT, 5'd1, 32'd3, 5'd2, 32'd9, 1'b0, 32'd0, 5'd4, 1'b0);
        step();
        chk("sgt_a",     alu_a,          32'd9);
        chk("sgt_b",     alu_b,          32'd3);
        chk("sgt_op",    32'(alu_op),    32'b110);
        chk("sgt_cruft", 32'(alu_cruft), 32'b10);

        // SRA cruft
        instr(FN_SRA, 5'd1, 32'h80, 5'd0, 32'd0, 1'b1, 32'd2, 5'd4, 1'b0);
        step();
        chk("sra_op",    32'(alu_op),    32'b000);
        chk("sra_cruft", 32'(alu_cruft), 32'b11);

        // SLE with immediate: swap after immediate selection
        instr(FN_SLE, 5'd1, 32'd10, 5'd2, 32'd99, 1'b1, 32'd20, 5'd4, 1'b0);
        step();
        chk("sle_a",     alu_a,          32'd20);
        chk("sle_b",     alu_b,          32'd10);
        chk("sle_cruft", 32'(alu_cruft), 32'b00);

        // ex_hold keeps the held instruction
        ex_hold = 1;
        instr(FN_XOR, 5'd1, 32'd1, 5'd2, 32'd2, 1'b0, 32'd0, 5'd5, 1'b0);
        #1;
        chk("hold_ready", 32'(in_ready), 32'd0);
        step();
        chk("hold_op",    32'(alu_op), 32'b110);
        chk("hold_a",     alu_a,       32'd20);

        // flush together with ex_hold
        flush = 1;
        step();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_op",    32'(alu_op),    32'b100);
        chk("flush_wen",   32'(out_wen),   32'd0);
        flush = 0; ex_hold = 0;
        instr(FN_XOR, 5'd1, 32'hF0, 5'd2, 32'hFF, 1'b0, 32'd0, 5'd5, 1'b0);
        step();
        chk("post_valid", 32'(out_valid), 32'd1);
        chk("post_op",    32'(alu_op),    32'b011);
        chk("post_a",     alu_a,          32'hF0);

        // Asynchronous reset mid-cycle
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_op",    32'(alu_op),    32'b000);
        in_valid = 0;
        #3;
        reset_n = 1'b1;
        #1;
        chk("arst_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
